// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port memory between an instruction-fetch requester
// and a data-stage requester, with a fixed wait-state count and IF starvation guard.
module mem_port_arbiter #(
    parameter int WAIT       = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,

    output logic        stall_if,
    output logic        stall_mem,

    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT);
    localparam logic [2:0] SKIP_LIM  = 3'(STARVE_MAX);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [2:0]  skip_cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        if_elig;
    logic        mem_elig;
    logic        grant_if;
    logic        grant_mem;
    logic        last_beat;

    // A requester whose ack is high this cycle is still holding req; it must not be re-granted.
    assign if_elig   = if_req  & ~if_ack;
    assign mem_elig  = mem_req & ~mem_ack;

    assign grant_if  = if_elig & (~mem_elig | (skip_cnt == SKIP_LIM));
    assign grant_mem = mem_elig & ~grant_if;
    assign last_beat = (wait_cnt == WAIT_LAST);

    assign stall_if  = if_req  & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;

    // NOTE: every register here uses <= so all updates see pre-edge values regardless of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            skip_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_if) begin
                        state    <= BUSY_IF;
                        lat_addr <= if_addr;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b0;
                        skip_cnt <= '0;
                    end else if (grant_mem) begin
                        state     <= BUSY_MEM;
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_we;
                        if (if_elig && skip_cnt != SKIP_LIM) begin
                            skip_cnt <= skip_cnt + 3'd1;
                        end
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (last_beat) begin
                        state  <= IDLE;
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_rdata;
                        end else begin
                            mem_ack <= 1'b1;
                            // Writes leave the previous read result visible.
                            if (!ram_we) begin
                                mem_rdata <= ram_rdata;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle table, reset-abort
// sequence, and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int WAIT       = 1;
    localparam int STARVE_MAX = 2;
    localparam int N_RANDOM   = 2000;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    mem_port_arbiter #(
        .WAIT       (WAIT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_owner;   // 0 none, 1 IF, 2 MEM
    int          m_left;    // busy cycles still to run
    int          m_skip;
    logic [31:0] m_addr, m_wdata, m_ird, m_mrd;
    logic        m_we, m_iack, m_mack;

    task automatic model_reset();
        m_owner = 0; m_left = 0; m_skip = 0;
        m_addr = '0; m_wdata = '0; m_ird = '0; m_mrd = '0;
        m_we = 1'b0; m_iack = 1'b0; m_mack = 1'b0;
    endtask

    task automatic model_update();
        logic ia, ma, ie, me;
        ia = 1'b0;
        ma = 1'b0;
        if (m_owner != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_owner == 1) begin
                    ia = 1'b1; m_ird = ram_rdata;
                end else begin
                    ma = 1'b1;
                    if (!m_we) m_mrd = ram_rdata;
                end
                m_owner = 0;
            end
        end else begin
            ie = if_req  && !m_iack;
            me = mem_req && !m_mack;
            if (ie && (!me || m_skip == STARVE_MAX)) begin
                m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_skip = 0; m_left = WAIT + 1;
            end else if (me) begin
                if (ie) m_skip = (m_skip + 1 > STARVE_MAX) ? STARVE_MAX : m_skip + 1;
                m_owner = 2; m_addr = mem_addr; m_wdata = mem_wdata; m_we = mem_we;
                m_left = WAIT + 1;
            end
        end
        m_iack = ia;
        m_mack = ma;
    endtask

    task automatic model_compare(input int cyc);
        check($sformatf("rnd%0d_ram_en", cyc),    ram_en,    m_owner != 0);
        check($sformatf("rnd%0d_ram_we", cyc),    ram_we,    m_owner == 2 && m_we);
        check($sformatf("rnd%0d_ram_addr", cyc),  ram_addr,  m_addr);
        check($sformatf("rnd%0d_ram_wdata", cyc), ram_wdata, m_wdata);
        check($sformatf("rnd%0d_if_ack", cyc),    if_ack,    m_iack);
        check($sformatf("rnd%0d_mem_ack", cyc),   mem_ack,   m_mack);
        check($sformatf("rnd%0d_if_rdata", cyc),  if_rdata,  m_ird);
        check($sformatf("rnd%0d_mem_rdata", cyc), mem_rdata, m_mrd);
        check($sformatf("rnd%0d_stall_if", cyc),  stall_if,  if_req && !m_iack);
        check($sformatf("rnd%0d_stall_mem", cyc), stall_mem, mem_req && !m_mack);
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        ir, mr, we;
        logic [31:0] maddr, wdata, rdat;
        logic        en, rwe;
        logic [31:0] addr, rwdata;
        logic        mack, iack;
        logic [31:0] mrd, ird;
        logic        sif, smem;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic ir, mr, we, input logic [31:0] maddr, wdata, rdat,
                           input logic en, rwe, input logic [31:0] addr, rwdata,
                           input logic mack, iack, input logic [31:0] mrd, ird,
                           input logic sif, smem);
        vec_t v;
        v = '{ir, mr, we, maddr, wdata, rdat, en, rwe, addr, rwdata, mack, iack, mrd, ird, sif, smem};
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        #1;
        check("rst_ram_en",    ram_en,    1'b0);
        check("rst_ram_we",    ram_we,    1'b0);
        check("rst_ram_addr",  ram_addr,  32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_if_ack",    if_ack,    1'b0);
        check("rst_mem_ack",   mem_ack,   1'b0);
        check("rst_if_rdata",  if_rdata,  32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);

        //       ir mr we maddr  wdata  rdat          en we addr   wdata  ma ia mrd           ird       si sm
        add_vec(0, 1, 0, 32'h10, 32'h0, 32'h0,        0, 0, 32'h0,  32'h0, 0, 0, 32'h0,        32'h0,  0, 1);
        add_vec(0, 1, 0, 32'h10, 32'h0, 32'h11111111, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,        32'h0,  0, 1);
        add_vec(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,        32'h0,  0, 1);
        add_vec(0, 1, 0, 32'h10, 32'h0, 32'h0,        0, 0, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF, 32'h0,  0, 0);
        add_vec(0, 0, 0, 32'h0,  32'h0, 32'h0,        0, 0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0,  0, 0);
        // write, then inputs change mid-transaction
        add_vec(0, 1, 1, 32'h20,  32'h55AA, 32'h0,    0, 0, 32'h10, 32'h0,    0, 0, 32'hDEADBEEF, 32'h0, 0, 1);
        add_vec(0, 1, 1, 32'h999, 32'h1234, 32'hCAFE, 1, 1, 32'h20, 32'h55AA, 0, 0, 32'hDEADBEEF, 32'h0, 0, 1);
        add_vec(0, 1, 1, 32'h999, 32'h1234, 32'hCAFE, 1, 1, 32'h20, 32'h55AA, 0, 0, 32'hDEADBEEF, 32'h0, 0, 1);
        add_vec(0, 1, 1, 32'h999, 32'h1234, 32'h0,    0, 0, 32'h20, 32'h55AA, 1, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        add_vec(0, 0, 0, 32'h0,   32'h0,    32'h0,    0, 0, 32'h20, 32'h55AA, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        // simultaneous requests: MEM first, IF granted in the MEM ack cycle
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0, 0, 0, 32'h20,  32'h55AA, 0, 0, 32'hDEADBEEF, 32'h0, 1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'hA, 1, 0, 32'h30,  32'h0,    0, 0, 32'hDEADBEEF, 32'h0, 1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'hB, 1, 0, 32'h30,  32'h0,    0, 0, 32'hDEADBEEF, 32'h0, 1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0, 0, 0, 32'h30,  32'h0,    1, 0, 32'hB,        32'h0, 1, 0);
        add_vec(1, 0, 0, 32'h0,  32'h0, 32'hC, 1, 0, 32'h100, 32'h0,    0, 0, 32'hB,        32'h0, 1, 0);
        add_vec(1, 0, 0, 32'h0,  32'h0, 32'hD, 1, 0, 32'h100, 32'h0,    0, 0, 32'hB,        32'h0, 1, 0);
        add_vec(1, 0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 32'h100, 32'h0,    0, 1, 32'hB,        32'hD, 0, 0);
        add_vec(0, 0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 32'h100, 32'h0,    0, 0, 32'hB,        32'hD, 0, 0);
        // starvation: IF skipped twice (it drops req in MEM ack cycles), then forced to win
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  0, 0, 32'h100, 32'h0, 0, 0, 32'hB,  32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  1, 0, 32'h30,  32'h0, 0, 0, 32'hB,  32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h20, 1, 0, 32'h30,  32'h0, 0, 0, 32'hB,  32'hD,  1, 1);
        add_vec(0, 1, 0, 32'h30, 32'h0, 32'h0,  0, 0, 32'h30,  32'h0, 1, 0, 32'h20, 32'hD,  0, 0);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  0, 0, 32'h30,  32'h0, 0, 0, 32'h20, 32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  1, 0, 32'h30,  32'h0, 0, 0, 32'h20, 32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h24, 1, 0, 32'h30,  32'h0, 0, 0, 32'h20, 32'hD,  1, 1);
        add_vec(0, 1, 0, 32'h30, 32'h0, 32'h0,  0, 0, 32'h30,  32'h0, 1, 0, 32'h24, 32'hD,  0, 0);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  0, 0, 32'h30,  32'h0, 0, 0, 32'h24, 32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  1, 0, 32'h100, 32'h0, 0, 0, 32'h24, 32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h28, 1, 0, 32'h100, 32'h0, 0, 0, 32'h24, 32'hD,  1, 1);
        add_vec(1, 1, 0, 32'h30, 32'h0, 32'h0,  0, 0, 32'h100, 32'h0, 0, 1, 32'h24, 32'h28, 0, 1);
        add_vec(0, 1, 0, 32'h30, 32'h0, 32'h0,  1, 0, 32'h30,  32'h0, 0, 0, 32'h24, 32'h28, 0, 1);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if_req = tbl[i].ir; if_addr = 32'h100;
            mem_req = tbl[i].mr; mem_we = tbl[i].we;
            mem_addr = tbl[i].maddr; mem_wdata = tbl[i].wdata; ram_rdata = tbl[i].rdat;
            #1;
            check($sformatf("t%0d_ram_en", i),    ram_en,    tbl[i].en);
            check($sformatf("t%0d_ram_we", i),    ram_we,    tbl[i].rwe);
            check($sformatf("t%0d_ram_addr", i),  ram_addr,  tbl[i].addr);
            check($sformatf("t%0d_ram_wdata", i), ram_wdata, tbl[i].rwdata);
            check($sformatf("t%0d_mem_ack", i),   mem_ack,   tbl[i].mack);
            check($sformatf("t%0d_if_ack", i),    if_ack,    tbl[i].iack);
            check($sformatf("t%0d_mem_rdata", i), mem_rdata, tbl[i].mrd);
            check($sformatf("t%0d_if_rdata", i),  if_rdata,  tbl[i].ird);
            check($sformatf("t%0d_stall_if", i),  stall_if,  tbl[i].sif);
            check($sformatf("t%0d_stall_mem", i), stall_mem, tbl[i].smem);
            @(negedge clk);
        end

        // reset in the second busy cycle aborts; the held request is then served in full
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; ram_rdata = 32'h77;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_pre_en", ram_en, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_en",    ram_en,    1'b0);
        check("abort_addr",  ram_addr,  32'h0);
        check("abort_ack",   mem_ack,   1'b0);
        check("abort_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k <= WAIT + 2; k++) begin
            #1;
            check($sformatf("rerun%0d_mem_ack", k), mem_ack, k == WAIT + 2);
            if (k == 1) check("rerun_addr", ram_addr, 32'h40);
            if (k == WAIT + 2) check("rerun_rdata", mem_rdata, 32'h77);
            @(negedge clk);
        end

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < N_RANDOM; c++) begin
            if (if_req) if_req = ($urandom_range(0, 7) != 0);
            else        if_req = ($urandom_range(0, 2) == 0);
            if (mem_req) mem_req = ($urandom_range(0, 7) != 0);
            else         mem_req = ($urandom_range(0, 2) == 0);
            mem_we    = $urandom_range(0, 1);
            if_addr   = $urandom;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            ram_rdata = $urandom;
            #1;
            model_compare(c);
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
